pci_initiator: RTL

PCI_INITIATOR -- requirements
Module: pci_initiator

---
 rtl/pci_pkg.sv | 35 +++
 rtl/pci_initiator_if.sv | 34 +++
 rtl/pci_timeout_ctr.sv | 32 +++
 rtl/pci_initiator.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/pci_pkg.sv
// Shared definitions for the PCI write initiator.
//   pci_state_e   : FSM state encoding
//   CMD_MEM_*     : PCI bus command codes
//   DEF_*         : default burst length and data-phase timeout
//   clamp_len     : maps a requested phase count onto 1..max_burst
package pci_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REQ_WAIT = 3'd1,
        ST_ADDR     = 3'd2,
        ST_DATA     = 3'd3,
        ST_TURN     = 3'd4
    } pci_state_e;

    localparam logic [3:0] CMD_MEM_READ  = 4'b0110;
    localparam logic [3:0] CMD_MEM_WRITE = 4'b0111;

    localparam int DEF_MAX_BURST = 8;
    localparam int DEF_TIMEOUT   = 16;

    // A request of 0 still moves one word; anything above the burst limit is cut back.
    function automatic logic [4:0] clamp_len(input logic [3:0] len, input int max_burst);
        logic [4:0] l;
        l = {1'b0, len};
        if (l == 5'd0) begin
            l = 5'd1;
        end
        if (int'(l) > max_burst) begin
            l = 5'(max_burst);
        end
        return l;
    endfunction

endpackage

// File: rtl/pci_initiator_if.sv
// Handshake and bus signals of the PCI write initiator.
//   master : the initiator itself (takes the request, drives REQ#/FRAME#/IRDY#/AD/CBE)
//   slave  : the surrounding system (requester, arbiter, bus and target)
interface pci_initiator_if;
    logic        start;
    logic [31:0] addr;
    logic [3:0]  cmd;
    logic [3:0]  len;
    logic [31:0] wdata;
    logic        GNT;
    logic        GLOBAL_FRAME;
    logic        GLOBAL_IRDY;
    logic        TRDY_GLOBAL;
    logic        REQ;
    logic        FRAME_OUT;
    logic        IRDY_OUT;
    logic [31:0] ad_out;
    logic [3:0]  cbe_out;
    logic        ad_oe;
    logic        data_ack;
    logic        busy;
    logic        done;
    logic        abort;

    modport master (
        input  start, addr, cmd, len, wdata, GNT, GLOBAL_FRAME, GLOBAL_IRDY, TRDY_GLOBAL,
        output REQ, FRAME_OUT, IRDY_OUT, ad_out, cbe_out, ad_oe, data_ack, busy, done, abort
    );

    modport slave (
        output start, addr, cmd, len, wdata, GNT, GLOBAL_FRAME, GLOBAL_IRDY, TRDY_GLOBAL,
        input  REQ, FRAME_OUT, IRDY_OUT, ad_out, cbe_out, ad_oe, data_ack, busy, done, abort
    );
endinterface

// File: rtl/pci_timeout_ctr.sv
// Counts data-phase cycles that pass without the target accepting the word.
//   clk, rst   : clock, async active-high reset
//   i_clear    : return the count to zero (takes priority)
//   i_enable   : advance one count this cycle
//   o_expired  : the current cycle is the TIMEOUT-th consecutive counted cycle
module pci_timeout_ctr
    import pci_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] r_count;

    assign o_expired = (r_count == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + 1'b1;
        end
    end
endmodule

// File: rtl/pci_initiator.sv
// PCI write-burst initiator: requests the bus, drives one address phase and
// up to MAX_BURST data phases, ends normally or by master abort.
//   clk, rst : clock, async active-high reset
//   bus      : pci_initiator_if.master (request side, arbiter, bus handshakes, status)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start
// REQ_WAIT | REQ# low, waiting for grant with the bus idle
// ADDR     | address phase, FRAME# low, AD = addr, C/BE = cmd
// DATA     | data phases, IRDY# low; also the FRAME#-high cycle of an abort
// TURN     | bus released, done or abort reported
module pci_initiator
    import pci_pkg::*;
#(
    parameter int MAX_BURST = DEF_MAX_BURST,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst,
    pci_initiator_if.master    bus
);
    pci_state_e  r_state, w_state_nxt;
    logic [31:0] r_addr, w_addr_nxt;
    logic [3:0]  r_cmd, w_cmd_nxt;
    logic [4:0]  r_remaining, w_remaining_nxt;
    logic        r_abort_pend, w_abort_pend_nxt;

    logic        r_req, w_req;
    logic        r_frame, w_frame;
    logic        r_irdy, w_irdy;
    logic [31:0] r_ad_out, w_ad_out;
    logic [3:0]  r_cbe, w_cbe;
    logic        r_ad_oe, w_ad_oe;
    logic        r_data_ack, w_data_ack;
    logic        r_busy, w_busy;
    logic        r_done, w_done;
    logic        r_abort, w_abort;

    logic        w_phase_done;
    logic        w_tmo_clear;
    logic        w_tmo_en;
    logic        w_tmo_expired;

    // Once FRAME# has been raised for an abort, a late TRDY# no longer completes a phase.
    assign w_phase_done = (r_state == ST_DATA) && !r_irdy && !bus.TRDY_GLOBAL && !r_abort_pend;

    pci_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_tmo_clear),
        .i_enable  (w_tmo_en),
        .o_expired (w_tmo_expired)
    );

    always_comb begin
        w_state_nxt      = r_state;
        w_addr_nxt       = r_addr;
        w_cmd_nxt        = r_cmd;
        w_remaining_nxt  = r_remaining;
        w_abort_pend_nxt = r_abort_pend;
        w_req            = r_req;
        w_frame          = r_frame;
        w_irdy           = r_irdy;
        w_ad_out         = r_ad_out;
        w_cbe            = r_cbe;
        w_ad_oe          = r_ad_oe;
        w_busy           = r_busy;
        w_data_ack       = 1'b0;
        w_done           = 1'b0;
        w_abort          = 1'b0;
        w_tmo_clear      = 1'b1;
        w_tmo_en         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_addr_nxt      = bus.addr;
                    w_cmd_nxt       = bus.cmd;
                    w_remaining_nxt = clamp_len(bus.len, MAX_BURST);
                    w_req           = 1'b0;
                    w_busy          = 1'b1;
                    w_state_nxt     = ST_REQ_WAIT;
                end
            end
            ST_REQ_WAIT: begin
                if (!bus.GNT && bus.GLOBAL_FRAME && bus.GLOBAL_IRDY) begin
                    w_frame     = 1'b0;
                    w_ad_out    = r_addr;
                    w_cbe       = r_cmd;
                    w_ad_oe     = 1'b1;
                    w_req       = 1'b1;
                    w_state_nxt = ST_ADDR;
                end
            end
            ST_ADDR: begin
                w_irdy      = 1'b0;
                w_ad_out    = bus.wdata;
                w_cbe       = 4'b0000;
                w_frame     = (r_remaining == 5'd1);
                w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (r_abort_pend) begin
                    w_irdy           = 1'b1;
                    w_frame          = 1'b1;
                    w_ad_oe          = 1'b0;
                    w_ad_out         = '0;
                    w_cbe            = 4'hF;
                    w_abort          = 1'b1;
                    w_abort_pend_nxt = 1'b0;
                    w_state_nxt      = ST_TURN;
                end else if (w_phase_done) begin
                    w_data_ack      = 1'b1;
                    w_remaining_nxt = r_remaining - 5'd1;
                    if (r_remaining == 5'd1) begin
                        w_irdy      = 1'b1;
                        w_frame     = 1'b1;
                        w_ad_oe     = 1'b0;
                        w_ad_out    = '0;
                        w_cbe       = 4'hF;
                        w_done      = 1'b1;
                        w_state_nxt = ST_TURN;
                    end else begin
                        // The next word is already on wdata; FRAME# rises as the last one goes out.
                        w_ad_out = bus.wdata;
                        w_frame  = (r_remaining == 5'd2);
                    end
                end else begin
                    w_tmo_clear = 1'b0;
                    w_tmo_en    = 1'b1;
                    if (w_tmo_expired) begin
                        w_frame          = 1'b1;
                        w_abort_pend_nxt = 1'b1;
                    end
                end
            end
            ST_TURN: begin
                w_busy      = 1'b0;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_cmd        <= '0;
            r_remaining  <= '0;
            r_abort_pend <= 1'b0;
            r_req        <= 1'b1;
            r_frame      <= 1'b1;
            r_irdy       <= 1'b1;
            r_ad_out     <= '0;
            r_cbe        <= 4'hF;
            r_ad_oe      <= 1'b0;
            r_data_ack   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_abort      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_addr       <= w_addr_nxt;
            r_cmd        <= w_cmd_nxt;
            r_remaining  <= w_remaining_nxt;
            r_abort_pend <= w_abort_pend_nxt;
            r_req        <= w_req;
            r_frame      <= w_frame;
            r_irdy       <= w_irdy;
            r_ad_out     <= w_ad_out;
            r_cbe        <= w_cbe;
            r_ad_oe      <= w_ad_oe;
            r_data_ack   <= w_data_ack;
            r_busy       <= w_busy;
            r_done       <= w_done;
            r_abort      <= w_abort;
        end
    end

    assign bus.REQ       = r_req;
    assign bus.FRAME_OUT = r_frame;
    assign bus.IRDY_OUT  = r_irdy;
    assign bus.ad_out    = r_ad_out;
    assign bus.cbe_out   = r_cbe;
    assign bus.ad_oe     = r_ad_oe;
    assign bus.data_ack  = r_data_ack;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.abort     = r_abort;
endmodule
